// File: rtl/sdhci_crc_pkg.sv
// Shared types and constants for the SDHCI serial CRC engine.
// Used by sdhci_crc_lane and sdhci_crc_multilane.
package sdhci_crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } crc_state_e;

    localparam int          CRC7_W     = 7;
    localparam int          CRC16_W    = 16;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sdhci_crc_lane.sv
// One serial CRC LFSR lane: accumulates payload bits, shifts the CRC out MSb first,
// or compares received CRC bits against its MSb and keeps a sticky mismatch flag.
module sdhci_crc_lane #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   POLY = W'(16'h1021)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic accum_i,
    input  logic shift_i,
    input  logic check_i,
    input  logic dat_i,
    output logic msb_o,
    output logic err_o
);

    logic [W-1:0] r_lfsr;
    logic         r_err;
    logic         w_fb;
    logic [W-1:0] w_shifted;

    // The same XOR serves as LFSR feedback while accumulating and as the
    // mismatch bit while checking a received CRC.
    assign w_fb      = dat_i ^ r_lfsr[W-1];
    assign w_shifted = {r_lfsr[W-2:0], 1'b0};

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_lfsr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (accum_i) begin
                r_lfsr <= w_shifted ^ (w_fb ? POLY : '0);
            end else if (shift_i || check_i) begin
                r_lfsr <= w_shifted;
            end
            if (check_i) begin
                r_err <= r_err | w_fb;
            end
        end
    end

    assign msb_o = r_lfsr[W-1];
    assign err_o = r_err;

endmodule

// File: rtl/sdhci_crc_multilane.sv
// Multi-lane serial CRC engine for SDHCI CMD/DAT lines: one LFSR per lane, shared FSM.
// Optional SDHCI_CRC_ERR_INJECT_EN adds err_inject_i to corrupt the first CRC bit of lane 0.
module sdhci_crc_multilane
    import sdhci_crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC16_POLY),
    parameter int                   NUM_LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef SDHCI_CRC_ERR_INJECT_EN
    input  logic                 err_inject_i,
`endif
    input  logic                 clk_en_i,
    input  logic                 start_i,
    input  logic                 gen_mode_i,
    input  logic                 dat_valid_i,
    input  logic [NUM_LANES-1:0] dat_i,
    input  logic                 end_i,
    output logic [NUM_LANES-1:0] crc_o,
    output logic                 crc_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_LANES-1:0] crc_err_o
);

    localparam int             CW       = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(CRC_WIDTH - 1);

    crc_state_e           r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic                 r_done, w_done_next;
    logic                 w_clr, w_accum, w_shift, w_check;
    logic                 w_crc_valid;
    logic [NUM_LANES-1:0] w_msb, w_err, w_inv_mask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Without a strobe everything holds, including the done pulse.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = r_done;
        w_clr        = 1'b0;
        w_accum      = 1'b0;
        w_shift      = 1'b0;
        w_check      = 1'b0;
        if (clk_en_i) begin
            w_done_next = 1'b0;
            if (start_i) begin
                w_clr        = 1'b1;
                w_state_next = ACCUM;
                w_cnt_next   = '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        w_state_next = IDLE;
                    end
                    ACCUM: begin
                        w_accum = dat_valid_i;
                        if (end_i) begin
                            w_state_next = gen_mode_i ? SHIFT : CHECK;
                        end
                    end
                    SHIFT, CHECK: begin
                        w_shift = (r_state == SHIFT);
                        w_check = (r_state == CHECK) && dat_valid_i;
                        if (w_shift || w_check) begin
                            if (r_cnt == LAST_CNT) begin
                                w_state_next = IDLE;
                                w_cnt_next   = '0;
                                w_done_next  = 1'b1;
                            end else begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_next = IDLE;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            sdhci_crc_lane #(
                .W    (CRC_WIDTH),
                .POLY (POLY)
            ) u_lane (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clr_i   (w_clr),
                .accum_i (w_accum),
                .shift_i (w_shift),
                .check_i (w_check),
                .dat_i   (dat_i[gi]),
                .msb_o   (w_msb[gi]),
                .err_o   (w_err[gi])
            );
        end
    endgenerate

    // The injected inversion touches only the output bit, never the LFSR.
`ifdef SDHCI_CRC_ERR_INJECT_EN
    assign w_inv_mask = NUM_LANES'(err_inject_i && (r_state == SHIFT) && (r_cnt == '0));
`else
    assign w_inv_mask = '0;
`endif

    assign w_crc_valid = (r_state == SHIFT);
    assign crc_o       = (w_msb & {NUM_LANES{w_crc_valid}}) ^ w_inv_mask;
    assign crc_valid_o = w_crc_valid;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign crc_err_o   = w_err;

endmodule

// File: tb/tb_sdhci_crc_multilane.sv
// Self-checking bench for sdhci_crc_multilane: a CRC7/1-lane and a CRC16/4-lane instance share
// one input stream; expected CRCs come from polynomial long division in the bench.
module tb_sdhci_crc_multilane;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       start = 1'b0;
    logic       gen_mode = 1'b0;
    logic       dat_valid = 1'b0;
    logic       end_in = 1'b0;
    logic [3:0] dat = 4'h0;

    logic [0:0] crc7, err7;
    logic       valid7, busy7, done7;
    logic [3:0] crc16, err16;
    logic       valid16, busy16, done16;

`ifdef SDHCI_CRC_ERR_INJECT_EN
    logic err_inject = 1'b0;
    bit   inj_req = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int gap = 0;

    logic [3:0]  msgq[$];
    logic [15:0] got[4];
    logic [15:0] exp_crc[4];

    always #5 clk = ~clk;

    sdhci_crc_multilane #(.CRC_WIDTH(7), .POLY(7'h09), .NUM_LANES(1)) u_crc7 (
        .clk_i(clk), .rst_i(rst),
`ifdef SDHCI_CRC_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .clk_en_i(clk_en), .start_i(start), .gen_mode_i(gen_mode),
        .dat_valid_i(dat_valid), .dat_i(dat[0:0]), .end_i(end_in),
        .crc_o(crc7), .crc_valid_o(valid7), .busy_o(busy7), .done_o(done7), .crc_err_o(err7)
    );

    sdhci_crc_multilane #(.CRC_WIDTH(16), .POLY(16'h1021), .NUM_LANES(4)) u_crc16 (
        .clk_i(clk), .rst_i(rst),
`ifdef SDHCI_CRC_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .clk_en_i(clk_en), .start_i(start), .gen_mode_i(gen_mode),
        .dat_valid_i(dat_valid), .dat_i(dat), .end_i(end_in),
        .crc_o(crc16), .crc_valid_o(valid16), .busy_o(busy16), .done_o(done16), .crc_err_o(err16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Remainder of (message * x^w) divided by (x^w + poly), message taken MSb first.
    function automatic logic [15:0] ref_crc(input int lane, input int w, input logic [15:0] poly);
        logic [16:0] rem;
        logic [16:0] g;
        int          n;
        logic        b;
        rem = '0;
        g   = (17'd1 << w) | {1'b0, poly};
        n   = msgq.size();
        for (int i = 0; i < n + w; i++) begin
            b   = (i < n) ? msgq[i][lane] : 1'b0;
            rem = {rem[15:0], b};
            if (rem[w]) rem = rem ^ g;
        end
        return rem[15:0];
    endfunction

    // Idle (clk_en low, junk inputs) for 'gap' cycles, then one enabled strobe.
    task automatic strobe(input logic s, input logic v, input logic e, input logic g, input logic [3:0] d);
        for (int k = 0; k < gap; k++) begin
            clk_en = 1'b0; start = rb(); dat_valid = rb(); end_in = rb();
            gen_mode = rb(); dat = 4'($urandom);
            @(negedge clk);
        end
        clk_en = 1'b1; start = s; dat_valid = v; end_in = e; gen_mode = g; dat = d;
        @(negedge clk);
        clk_en = 1'b0; start = 1'b0; dat_valid = 1'b0; end_in = 1'b0;
    endtask

    task automatic send_payload(input logic g, input int bubbles);
        int n;
        strobe(1'b1, rb(), rb(), rb(), 4'($urandom));
        chk("start_busy7", busy7, 1'b1);
        chk("start_busy16", busy16, 1'b1);
        n = msgq.size();
        if (n == 0) begin
            strobe(1'b0, 1'b0, 1'b1, g, 4'($urandom));
        end else begin
            for (int i = 0; i < n; i++) begin
                if (bubbles > 0) begin
                    repeat ($urandom_range(0, bubbles)) strobe(1'b0, 1'b0, 1'b0, rb(), 4'($urandom));
                end
                strobe(1'b0, 1'b1, (i == n - 1), g, msgq[i]);
            end
        end
    endtask

    task automatic shift_out(input int w);
        for (int l = 0; l < 4; l++) got[l] = '0;
        for (int k = 0; k < w; k++) begin
`ifdef SDHCI_CRC_ERR_INJECT_EN
            if (inj_req && k == 0) begin
                err_inject = 1'b1;
                #1;
            end
`endif
            chk("shift_valid", (w == 7) ? valid7 : valid16, 1'b1);
            chk("shift_done_early", (w == 7) ? done7 : done16, 1'b0);
            if (w == 7) got[0] = {got[0][14:0], crc7[0]};
            else for (int l = 0; l < 4; l++) got[l] = {got[l][14:0], crc16[l]};
`ifdef SDHCI_CRC_ERR_INJECT_EN
            err_inject = 1'b0;
            inj_req = 1'b0;
`endif
            strobe(1'b0, rb(), rb(), rb(), 4'($urandom));
        end
        chk("shift_done", (w == 7) ? done7 : done16, 1'b1);
        chk("shift_idle", (w == 7) ? busy7 : busy16, 1'b0);
        chk("shift_valid_off", (w == 7) ? valid7 : valid16, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom));
        chk("done_pulse", (w == 7) ? done7 : done16, 1'b0);
        chk("end_in_idle", (w == 7) ? busy7 : busy16, 1'b0);
    endtask

    task automatic check_in(input int w, input logic [3:0] flip, input int fbit, input int bubbles);
        logic [3:0] d;
        int         j;
        for (int k = 0; k < w; k++) begin
            j = w - 1 - k;
            if (bubbles > 0) begin
                repeat ($urandom_range(0, bubbles)) strobe(1'b0, 1'b0, rb(), rb(), 4'($urandom));
            end
            chk("check_done_early", (w == 7) ? done7 : done16, 1'b0);
            for (int l = 0; l < 4; l++) d[l] = exp_crc[l][j] ^ (flip[l] && (j == fbit));
            strobe(1'b0, 1'b1, 1'b0, rb(), d);
        end
        chk("check_done", (w == 7) ? done7 : done16, 1'b1);
        chk("check_idle", (w == 7) ? busy7 : busy16, 1'b0);
        if (w == 7) chk("check_err7", err7, flip[0]);
        else        chk("check_err16", err16, flip);
    endtask

    task automatic load_word(input logic [39:0] v);
        msgq.delete();
        for (int i = 39; i >= 0; i--) msgq.push_back({4{v[i]}});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_crc7", crc7, 1'b0);
        chk("rst_valid7", valid7, 1'b0);
        chk("rst_busy7", busy7, 1'b0);
        chk("rst_done7", done7, 1'b0);
        chk("rst_err7", err7, 1'b0);
        chk("rst_crc16", crc16, 4'h0);
        chk("rst_valid16", valid16, 1'b0);
        chk("rst_busy16", busy16, 1'b0);
        chk("rst_done16", done16, 1'b0);
        chk("rst_err16", err16, 4'h0);

        // CMD0 CRC7
        load_word(40'h40_0000_0000);
        send_payload(1'b1, 0);
        shift_out(7);
        chk("cmd0_crc7", got[0], 16'h004A);

        // CMD17, one enabled strobe in three
        gap = 2;
        load_word(40'h51_0000_0000);
        send_payload(1'b1, 0);
        shift_out(7);
        chk("cmd17_crc7_gapped", got[0], 16'h002A);
        gap = 0;

        // 512 bytes of 0xFF on every lane: generate then check
        msgq.delete();
        repeat (4096) msgq.push_back(4'hF);
        send_payload(1'b1, 0);
        shift_out(16);
        for (int l = 0; l < 4; l++) chk("ff512_crc16", got[l], 16'h7FA1);
        send_payload(1'b0, 0);
        for (int l = 0; l < 4; l++) exp_crc[l] = 16'h7FA1;
        check_in(16, 4'b0000, 0, 0);

        // Check mode, lane 2 CRC bit 5 corrupted
        msgq.delete();
        repeat (64) msgq.push_back(4'($urandom));
        for (int l = 0; l < 4; l++) exp_crc[l] = ref_crc(l, 16, 16'h1021);
        send_payload(1'b0, 2);
        check_in(16, 4'b0100, 5, 2);
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        chk("err_sticky", err16, 4'b0100);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
        chk("err_cleared_by_start", err16, 4'b0000);
        repeat (3) strobe(1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom));
        clk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy16", busy16, 1'b0);
        chk("midrst_busy7", busy7, 1'b0);
        chk("midrst_outs16", {crc16, valid16, done16, err16}, 10'h0);
        chk("midrst_outs7", {crc7, valid7, done7, err7}, 4'h0);

        // Abort on the 3rd SHIFT strobe, then an empty payload must give CRC 0
        msgq.delete();
        repeat (20) msgq.push_back(4'($urandom));
        send_payload(1'b1, 1);
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        chk("abort_pre_valid", valid16, 1'b1);
        strobe(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom));
        chk("abort_valid", valid16, 1'b0);
        chk("abort_done", done16, 1'b0);
        chk("abort_busy", busy16, 1'b1);
        strobe(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom));
        shift_out(16);
        for (int l = 0; l < 4; l++) chk("abort_cleared_crc", got[l], 16'h0000);

        // Randomised frames against the division model
        for (int it = 0; it < 8; it++) begin
            int         n;
            int         w;
            int         fb;
            logic [3:0] mask;
            n = $urandom_range(0, 40);
            w = it[0] ? 16 : 7;
            gap = $urandom_range(0, 1);
            msgq.delete();
            repeat (n) msgq.push_back(4'($urandom));
            for (int l = 0; l < 4; l++)
                exp_crc[l] = (w == 16) ? ref_crc(l, 16, 16'h1021) : ref_crc(l, 7, 16'h0009);
            if (it[1]) begin
                send_payload(1'b1, 1);
                shift_out(w);
                for (int l = 0; l < ((w == 16) ? 4 : 1); l++) chk("rand_gen", got[l], exp_crc[l]);
            end else begin
                send_payload(1'b0, 1);
                mask = (w == 16) ? 4'($urandom) : 4'($urandom_range(0, 1));
                fb = $urandom_range(0, w - 1);
                check_in(w, mask, fb, 1);
            end
        end
        gap = 0;

`ifdef SDHCI_CRC_ERR_INJECT_EN
        load_word(40'h40_0000_0000);
        send_payload(1'b1, 0);
        inj_req = 1'b1;
        shift_out(7);
        chk("inject_cmd0", got[0], 16'h000A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
